pe_mac_accum: RTL and testbench

- Processing-element MAC stage directly downstream of the weight buffer.
- Pairs each streamed weight with an activation sample and multiplies them as signed values.
- Accumulates kernel_size products into one partial sum, then emits the sum on a valid/ready output toward the PE-array reduction/output stage.
- One window per start pulse.

---
 rtl/pe_mac_accum_pkg.sv | 32 +++
 rtl/pe_mac_accum_if.sv | 42 ++++
 rtl/pe_mult_stage.sv | 40 ++++
 rtl/pe_mac_accum.sv | 157 +++++++++++++++
 tb/tb_pe_mac_accum.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_mac_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_accum_pkg
//  Description : Shared widths, FSM state encodings and saturation helpers
//                for the PE multiply-accumulate stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_mac_accum_pkg;

    // Default widths for the weight/activation words, the accumulator and the kernel count
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_KS_WIDTH   = 8;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ACCUM = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;
    localparam logic [1:0] ST_OUT   = 2'b11;

    // Largest value representable in a signed word of width dw
    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed word of width dw
    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_accum_if
//  Description : Control, weight/activation stream and partial-sum output
//                bundle of the PE MAC stage. master = producer/consumer side,
//                slave = the MAC stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_mac_accum_if
    import pe_mac_accum_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int KS_WIDTH   = DEF_KS_WIDTH
) ();

    logic        [KS_WIDTH-1:0]   kernel_size;
    logic                         start;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic                         w_valid;
    logic                         w_ready;
    logic signed [DATA_WIDTH-1:0] x_data;
    logic                         x_valid;
    logic                         x_ready;
    logic signed [ACC_WIDTH-1:0]  psum_out;
    logic                         psum_valid;
    logic                         psum_ready;
    logic                         busy;
    logic                         overflow;

    modport master (
        output kernel_size, start, w_data, w_valid, x_data, x_valid, psum_ready,
        input  w_ready, x_ready, psum_out, psum_valid, busy, overflow
    );

    modport slave (
        input  kernel_size, start, w_data, w_valid, x_data, x_valid, psum_ready,
        output w_ready, x_ready, psum_out, psum_valid, busy, overflow
    );

endinterface
`default_nettype wire

// File: rtl/pe_mult_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mult_stage
//  Description : Registered full-precision signed multiplier; the valid flag
//                travels alongside the product so bubbles stay bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_mult_stage #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_valid,
    input  logic signed [DATA_WIDTH-1:0]   i_a,
    input  logic signed [DATA_WIDTH-1:0]   i_b,
    output logic                           o_valid,
    output logic signed [2*DATA_WIDTH-1:0] o_prod
);

    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic                           r_valid;

    // Capture the product of a fired beat; valid follows every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prod  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_prod <= i_a * i_b;
            end
        end
    end

    assign o_prod  = r_prod;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pe_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_accum
//  Description : PE MAC stage. Pairs weight and activation beats, multiplies
//                them (registered), accumulates kernel_size products and
//                presents the partial sum on a valid/ready output.
//                Optional build macro PE_PSUM_SAT_EN: clip the result to the
//                signed DATA_WIDTH range and raise a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_accum
    import pe_mac_accum_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int KS_WIDTH   = DEF_KS_WIDTH
) (
    input  logic          clk,
    input  logic          rstn,
    pe_mac_accum_if.slave bus
);

    localparam int c_prod_width = 2 * DATA_WIDTH;

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_nxt;
    logic [KS_WIDTH-1:0]            r_ks_q;
    logic [KS_WIDTH-1:0]            r_beat_cnt;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_acc_nxt;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_psum_sel;
    logic signed [ACC_WIDTH-1:0]    r_psum_out;
    logic                           r_overflow;
    logic                           w_clip;
    logic                           w_start_acc;
    logic                           w_beat;
    logic                           w_last_beat;
    logic                           w_enter_out;
    logic                           w_prod_vld;
    logic signed [c_prod_width-1:0] w_prod;

    assign w_start_acc = (r_state == ST_IDLE) && bus.start;
    assign w_beat      = (r_state == ST_ACCUM) && bus.w_valid && bus.x_valid;
    assign w_last_beat = w_beat && ((r_beat_cnt + KS_WIDTH'(1)) == r_ks_q);
    assign w_enter_out = (w_state_nxt == ST_OUT) && (r_state != ST_OUT);
    assign w_prod_ext  = {{(ACC_WIDTH - c_prod_width){w_prod[c_prod_width-1]}}, w_prod};

    pe_mult_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (w_beat),
        .i_a     (bus.w_data),
        .i_b     (bus.x_data),
        .o_valid (w_prod_vld),
        .o_prod  (w_prod)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: an empty window goes straight to OUT with a zero sum
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = (bus.kernel_size == '0) ? ST_OUT : ST_ACCUM;
            ST_ACCUM: if (w_last_beat) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_OUT;
            ST_OUT:   if (bus.psum_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: each stream is ready only when its partner is valid, so beats pair up
    always_comb begin
        bus.w_ready    = (r_state == ST_ACCUM) && bus.x_valid;
        bus.x_ready    = (r_state == ST_ACCUM) && bus.w_valid;
        bus.psum_valid = (r_state == ST_OUT);
        bus.busy       = (r_state != ST_IDLE);
        bus.psum_out   = r_psum_out;
        bus.overflow   = r_overflow;
    end

    // Window length latch and beat counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ks_q     <= '0;
            r_beat_cnt <= '0;
        end else if (w_start_acc) begin
            r_ks_q     <= bus.kernel_size;
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + KS_WIDTH'(1);
        end
    end

    // Accumulator update: cleared at window start, adds the registered product when valid
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_start_acc) begin
            w_acc_nxt = '0;
        end else if (w_prod_vld) begin
            w_acc_nxt = r_acc + w_prod_ext;
        end
    end

    // Accumulator register (wraps modulo 2^ACC_WIDTH)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

`ifdef PE_PSUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min = ACC_WIDTH'(sat_min(DATA_WIDTH));

    // Clip the final sum to the signed word range
    always_comb begin
        w_clip     = 1'b0;
        w_psum_sel = w_acc_nxt;
        if (w_acc_nxt > c_sat_max) begin
            w_clip     = 1'b1;
            w_psum_sel = c_sat_max;
        end else if (w_acc_nxt < c_sat_min) begin
            w_clip     = 1'b1;
            w_psum_sel = c_sat_min;
        end
    end
`else
    assign w_clip     = 1'b0;
    assign w_psum_sel = w_acc_nxt;
`endif

    // Result register loaded on entry to OUT (sees the last product via w_acc_nxt); sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_psum_out <= '0;
            r_overflow <= 1'b0;
        end else if (w_enter_out) begin
            r_psum_out <= w_psum_sel;
            r_overflow <= r_overflow | w_clip;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_mac_accum
//  Description : Scoreboard bench for pe_mac_accum: windows are modelled as
//                plain sums of products, expected results queued at issue and
//                popped by an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_accum;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    pe_mac_accum_if bif ();

    pe_mac_accum dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    typedef struct {
        longint psum;
        bit     ovf;
    } exp_t;

    exp_t   sb_q[$];
    longint cur_w[$];
    longint cur_x[$];
    int     n_err     = 0;
    int     n_chk     = 0;
    bit     model_ovf = 1'b0;
    int     rdy_mode  = 1;   // 0: hold low, 1: hold high, 2: random
    int     vmode     = 0;   // 0: both valid, 1: x gaps every other cycle, 2: random gaps

    function automatic void check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Reference: window result is the plain sum of w*x, clipped when saturation is built in
    function automatic exp_t model(input int ks);
        exp_t   r;
        longint s = 0;
        for (int i = 0; i < ks; i++) s += cur_w[i] * cur_x[i];
`ifdef PE_PSUM_SAT_EN
        if (s > 32767) begin
            s = 32767;
            model_ovf = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            model_ovf = 1'b1;
        end
`endif
        r.psum = s;
        r.ovf  = model_ovf;
        return r;
    endfunction

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) bif.psum_ready = 1'($urandom_range(0, 1));
            else               bif.psum_ready = (rdy_mode == 1);
        end
    end

    // Output monitor: pops the scoreboard on every psum handshake, checks stream pairing
    initial begin
        exp_t              e;
        logic signed [39:0] e40;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (!bif.x_valid) check("w_ready_without_x_valid", bif.w_ready, 0);
                if (!bif.w_valid) check("x_ready_without_w_valid", bif.x_ready, 0);
                if (bif.psum_valid && bif.psum_ready) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_psum: actual=%0d required=none", bif.psum_out);
                    end else begin
                        e   = sb_q.pop_front();
                        e40 = e.psum[39:0];
                        check("psum_out", bif.psum_out, e40);
                        check("overflow", bif.overflow, e.ovf);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bif.busy) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                n_chk++;
                n_err++;
                $display("FAIL idle_timeout: actual=busy required=idle");
                return;
            end
        end
    endtask

    task automatic start_window(input int ks);
        wait_idle();
        @(posedge clk);
        #1;
        bif.kernel_size = 8'(ks);
        bif.start       = 1'b1;
        @(posedge clk);
        #1;
        bif.start       = 1'b0;
        bif.kernel_size = 8'($urandom);
    endtask

    // Feed n paired beats with the current gap pattern; optionally check output latency
    task automatic stream(input int n, input bit do_lat);
        int idx = 0;
        int t   = 0;
        while (idx < n) begin
            case (vmode)
                0:       begin bif.w_valid = 1'b1; bif.x_valid = 1'b1; end
                1:       begin bif.w_valid = 1'b1; bif.x_valid = ((t % 2) == 0); end
                default: begin
                    bif.w_valid = ($urandom_range(0, 3) != 0);
                    bif.x_valid = ($urandom_range(0, 3) != 0);
                end
            endcase
            bif.w_data = 16'(cur_w[idx]);
            bif.x_data = 16'(cur_x[idx]);
            @(negedge clk);
            if (bif.w_valid && bif.x_valid && bif.w_ready && bif.x_ready) idx++;
            @(posedge clk);
            #1;
            t++;
            if (t > 400) begin
                n_chk++;
                n_err++;
                $display("FAIL beat_timeout: actual=%0d required=%0d beats", idx, n);
                break;
            end
        end
        bif.w_valid = 1'b0;
        bif.x_valid = 1'b0;
        if (do_lat) begin
            @(negedge clk);
            check("lat_drain_psum_valid", bif.psum_valid, 0);
            @(negedge clk);
            check("lat_out_psum_valid", bif.psum_valid, 1);
        end
    endtask

    task automatic run_window(input int ks);
        sb_q.push_back(model(ks));
        start_window(ks);
        stream(ks, 1'b1);
    endtask

    task automatic load_random(input int ks);
        cur_w.delete();
        cur_x.delete();
        for (int i = 0; i < ks; i++) begin
            cur_w.push_back(longint'($signed(16'($urandom))));
            cur_x.push_back(longint'($signed(16'($urandom))));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psum_valid"}, bif.psum_valid, 0);
        check({tag, "_psum_out"},   bif.psum_out,   0);
        check({tag, "_w_ready"},    bif.w_ready,    0);
        check({tag, "_x_ready"},    bif.x_ready,    0);
        check({tag, "_busy"},       bif.busy,       0);
        check({tag, "_overflow"},   bif.overflow,   0);
    endtask

    initial begin
        logic signed [39:0] held;
        int                 ks;
        int                 t;

        bif.kernel_size = '0;
        bif.start       = 1'b0;
        bif.w_data      = '0;
        bif.w_valid     = 1'b0;
        bif.x_data      = '0;
        bif.x_valid     = 1'b0;
        bif.psum_ready  = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Continuous streams: 10 - 18 - 4 = -12
        vmode = 0;
        cur_w = '{2, -3, 4};
        cur_x = '{5, 6, -1};
        run_window(3);

        // Activation gaps every other cycle: 7 + 8 + 9 + 10 = 34
        vmode = 1;
        cur_w = '{1, 1, 1, 1};
        cur_x = '{7, 8, 9, 10};
        run_window(4);

        // Empty window: result on the very next cycle, nothing consumed
        cur_w.delete();
        cur_x.delete();
        sb_q.push_back(model(0));
        start_window(0);
        bif.w_valid = 1'b1;
        bif.x_valid = 1'b1;
        @(negedge clk);
        check("ks0_psum_valid", bif.psum_valid, 1);
        check("ks0_w_ready", bif.w_ready, 0);
        check("ks0_x_ready", bif.x_ready, 0);
        @(posedge clk);
        #1;
        bif.w_valid = 1'b0;
        bif.x_valid = 1'b0;

        // Back-pressure: result held while psum_ready is low, start ignored
        rdy_mode = 0;
        vmode    = 0;
        cur_w    = '{3, -5};
        cur_x    = '{4, 2};
        run_window(2);
        held = bif.psum_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bif.start       = 1'b1;
            bif.kernel_size = 8'd7;
            bif.w_valid     = 1'b1;
            bif.x_valid     = 1'b1;
            @(negedge clk);
            check("hold_psum_out", bif.psum_out, held);
            check("hold_psum_valid", bif.psum_valid, 1);
            check("hold_busy", bif.busy, 1);
            check("hold_w_ready", bif.w_ready, 0);
            check("hold_x_ready", bif.x_ready, 0);
        end
        bif.start   = 1'b0;
        bif.w_valid = 1'b0;
        bif.x_valid = 1'b0;
        rdy_mode    = 1;
        @(negedge clk);
        @(negedge clk);
        check("release_busy", bif.busy, 0);
        check("release_psum_valid", bif.psum_valid, 0);
        @(negedge clk);
        check("release_no_restart", bif.busy, 0);

        // Large products: clip to 32767 with saturation, full 2147352578 without
        vmode = 2;
        cur_w = '{32767, 32767};
        cur_x = '{32767, 32767};
        run_window(2);
        cur_w = '{1};
        cur_x = '{1};
        run_window(1);

        // Randomized windows with gaps and random downstream back-pressure
        rdy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            ks = $urandom_range(1, 8);
            load_random(ks);
            run_window(ks);
        end

        // Reset part way through a window discards the partial work
        wait_idle();
        rdy_mode = 1;
        vmode    = 0;
        load_random(5);
        start_window(5);
        stream(2, 1'b0);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        cur_w = '{3};
        cur_x = '{3};
        run_window(1);

        rdy_mode = 2;
        vmode    = 2;
        for (int n = 0; n < 6; n++) begin
            ks = $urandom_range(1, 8);
            load_random(ks);
            run_window(ks);
        end

        wait_idle();
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
